// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with a zero-fill sweep after reset
// or on clear_req. Define REG_ARB_R0_LOCK_EN to block writes to r0 and flag attempts.
module reg_wr_arbiter #(
  parameter int unsigned pw   = 3,
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*pw-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clear_req,
  output logic               wr_en,
  output logic [pw-1:0]      wr_addr,
  output logic [DW-1:0]      dat_in,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               r0_viol
);

`ifdef REG_ARB_R0_LOCK_EN
  localparam bit R0Lock = 1'b1;
`else
  localparam bit R0Lock = 1'b0;
`endif

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e          state_q, state_d;
  logic [pw-1:0]   ctr_q, ctr_d;
  logic [1:0]      rr_last_q, rr_last_d;
  logic            wr_en_q, wr_en_d;
  logic [pw-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   dat_in_q, dat_in_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic            r0_viol_q, r0_viol_d;

  logic            grant_vld;
  logic [1:0]      grant_idx;
  logic [pw-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;
  logic            arb_en;

  assign arb_en = (state_q == StArb) && !reset;

  // First valid requester searching upward from the one after the last winner.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last_q) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(idx);
      end
    end
  end

  assign grant_addr = req_addr[grant_idx*pw +: pw];
  assign grant_data = req_data[grant_idx*DW +: DW];
  assign req_ready  = (arb_en && grant_vld) ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    rr_last_d  = rr_last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    dat_in_d   = dat_in_q;
    grant_id_d = grant_id_q;
    r0_viol_d  = r0_viol_q;
    unique case (state_q)
      StClear: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ctr_q;
        dat_in_d  = '0;
        ctr_d     = ctr_q + pw'(1);
        if (ctr_q == {pw{1'b1}}) state_d = StArb;
      end
      StArb: begin
        if (grant_vld) begin
          rr_last_d = grant_idx;
          if (R0Lock && (grant_addr == '0)) begin
            r0_viol_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = grant_addr;
            dat_in_d   = grant_data;
            grant_id_d = grant_idx;
          end
        end
        // The grant made this cycle still lands; the sweep starts next cycle.
        if (clear_req) begin
          state_d = StClear;
          ctr_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClear;
      ctr_q      <= '0;
      rr_last_q  <= 2'(NREQ - 1);
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      dat_in_q   <= '0;
      grant_id_q <= '0;
      r0_viol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      rr_last_q  <= rr_last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      dat_in_q   <= dat_in_d;
      grant_id_q <= grant_id_d;
      r0_viol_q  <= r0_viol_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign dat_in   = dat_in_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == StClear);
  assign r0_viol  = R0Lock ? r0_viol_q : 1'b0;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed testbench for reg_wr_arbiter (pw=3, NREQ=3, DW=8) with a small register file
// model that commits wr_* so write ordering can be observed.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        clear_req;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  dat_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic        r0_viol;

  logic [7:0]  rf [8];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.pw(3), .NREQ(3), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .dat_in    (dat_in),
    .grant_id  (grant_id),
    .busy      (busy),
    .r0_viol   (r0_viol)
  );

  always @(posedge clk) if (wr_en) rf[wr_addr] <= dat_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      #1 check({tag, " ready"}, 32'(req_ready), 32'd0);
      tick();
      check({tag, " wr_en"}, 32'(wr_en), 32'd1);
      check({tag, " addr"}, 32'(wr_addr), 32'(i));
      check({tag, " data"}, 32'(dat_in), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'(i < 7));
    end
  endtask

  initial begin
    logic [7:0] dat_tab [3];
    dat_tab[0] = 8'h11; dat_tab[1] = 8'h22; dat_tab[2] = 8'h33;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clear_req = 1'b0;

    // 1: reset then full zero-fill sweep
    #1 check("reset ready", 32'(req_ready), 32'd0);
    tick();
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset gid", 32'(grant_id), 32'd0);
    check("reset viol", 32'(r0_viol), 32'd0);
    reset = 1'b0;
    check_sweep("sweep1");

    // 2: all valid, round robin starting at req0
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, 3'(i + 1), dat_tab[i]);
    for (int k = 0; k < 6; k++) begin
      #1 check("rr ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
      tick();
      check("rr wr_en", 32'(wr_en), 32'd1);
      check("rr addr", 32'(wr_addr), 32'((k % 3) + 1));
      check("rr data", 32'(dat_in), 32'(dat_tab[k % 3]));
      check("rr gid", 32'(grant_id), 32'(k % 3));
    end

    // 3: same address from req0 and req2; later grant wins
    req_valid = 3'b101;
    set_req(0, 3'd5, 8'hA5);
    set_req(2, 3'd5, 8'h5A);
    #1 check("same ready0", 32'(req_ready), 32'b001);
    tick();
    check("same data0", 32'(dat_in), 32'hA5);
    check("same ready2", 32'(req_ready), 32'b100);
    tick();
    check("same data2", 32'(dat_in), 32'h5A);
    check("same gid2", 32'(grant_id), 32'd2);
    req_valid = '0;
    #1 check("idle ready", 32'(req_ready), 32'd0);
    tick();
    check("idle wr_en", 32'(wr_en), 32'd0);
    check("idle addr hold", 32'(wr_addr), 32'd5);
    check("rf r5", 32'(rf[5]), 32'h5A);

    // 4: clear_req with req1 pending; clear_req mid-sweep ignored
    req_valid = 3'b010;
    set_req(1, 3'd4, 8'h77);
    clear_req = 1'b1;
    #1 check("clr ready", 32'(req_ready), 32'b010);
    tick();
    clear_req = 1'b0;
    check("clr wr_addr", 32'(wr_addr), 32'd4);
    check("clr data", 32'(dat_in), 32'h77);
    check("clr gid", 32'(grant_id), 32'd1);
    check("clr busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      clear_req = (i == 3);
      #1 check("clr sw ready", 32'(req_ready), 32'd0);
      tick();
      check("clr sw addr", 32'(wr_addr), 32'(i));
      check("clr sw data", 32'(dat_in), 32'd0);
    end
    clear_req = 1'b0;
    check("clr done busy", 32'(busy), 32'd0);
    #1 check("clr re ready", 32'(req_ready), 32'b010);
    tick();
    check("clr re addr", 32'(wr_addr), 32'd4);
    check("clr re data", 32'(dat_in), 32'h77);
    req_valid = '0;

    // 5: reset at sweep address 3, pending req0 survives
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("rst5 busy", 32'(busy), 32'd1);
    req_valid = 3'b001;
    set_req(0, 3'd6, 8'h66);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst5 pre addr", 32'(wr_addr), 32'(i));
    end
    reset = 1'b1;
    #1 check("rst5 ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    check("rst5 wr_en", 32'(wr_en), 32'd0);
    check("rst5 addr", 32'(wr_addr), 32'd0);
    check_sweep("sweep5");
    #1 check("rst5 req ready", 32'(req_ready), 32'b001);
    tick();
    check("rst5 req addr", 32'(wr_addr), 32'd6);
    check("rst5 req data", 32'(dat_in), 32'h66);
    req_valid = '0;
    tick();

    // 6: write to r0
    req_valid = 3'b001;
    set_req(0, 3'd0, 8'hFF);
    #1 check("r0 ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
`ifdef REG_ARB_R0_LOCK_EN
    check("r0 wr_en", 32'(wr_en), 32'd0);
    check("r0 viol", 32'(r0_viol), 32'd1);
    tick();
    check("r0 viol sticky", 32'(r0_viol), 32'd1);
`else
    check("r0 wr_en", 32'(wr_en), 32'd1);
    check("r0 addr", 32'(wr_addr), 32'd0);
    check("r0 data", 32'(dat_in), 32'hFF);
    check("r0 viol", 32'(r0_viol), 32'd0);
    tick();
    check("rf r0", 32'(rf[0]), 32'hFF);
`endif
    check("r0 idle wr_en", 32'(wr_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
